// File: rtl/bsg_mul_share_pkg.sv
// Shared types and helpers for the multiplier-sharing controller.
// The tag id field is sized for up to 2**tag_id_w requesters; narrower ids are zero-extended.
package bsg_mul_share_pkg;

    localparam int unsigned tag_id_w = 8;

    function automatic int unsigned lg(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                v;
        logic [tag_id_w-1:0] id;
    } bsg_mul_share_tag_s;

endpackage

// File: rtl/bsg_mul_share_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after ptr (wrapping).
// ptr advances past the granted requester only when the grant is accepted.
module bsg_mul_share_rr_arb
    import bsg_mul_share_pkg::*;
#(
    parameter  int unsigned num_req_p = 4,
    localparam int unsigned id_w      = lg(num_req_p)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [num_req_p-1:0] req,
    input  logic                 accept,
    output logic [num_req_p-1:0] grant,
    output logic [id_w-1:0]      grant_idx,
    output logic                 any
);

    logic [id_w-1:0] ptr;

    always_comb begin : scan
        logic [id_w:0]   sum;
        logic [id_w-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            sum = {1'b0, ptr} + (id_w+1)'(k);
            if (sum >= (id_w+1)'(num_req_p)) begin
                sum = sum - (id_w+1)'(num_req_p);
            end
            idx = sum[id_w-1:0];
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (grant_idx == id_w'(num_req_p - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/bsg_mul_share_ctrl.sv
// Shares one pipelined multiplier among num_req_p requesters with id-tagged results.
// Optional perf counters (issued_o, stall_o) are enabled by defining BSG_MUL_SHARE_CTRL_PERF_EN.
module bsg_mul_share_ctrl
    import bsg_mul_share_pkg::*;
#(
    parameter int unsigned width_p       = 32,
    parameter int unsigned num_req_p     = 4,
    parameter int unsigned pipe_stages_p = 4
) (
    input  logic                           clock_i,
    input  logic                           reset_n_i,
    input  logic [num_req_p-1:0]           v_i,
    input  logic [num_req_p*width_p-1:0]   x_i,
    input  logic [num_req_p*width_p-1:0]   y_i,
    input  logic [num_req_p-1:0]           signed_i,
    output logic [num_req_p-1:0]           ready_o,
    output logic                           mul_en_o,
    output logic [width_p-1:0]             mul_x_o,
    output logic [width_p-1:0]             mul_y_o,
    output logic                           mul_signed_o,
    input  logic [2*width_p-1:0]           mul_z_i,
    output logic                           v_o,
    output logic [lg(num_req_p)-1:0]       id_o,
    output logic [2*width_p-1:0]           z_o,
    input  logic                           yumi_i
`ifdef BSG_MUL_SHARE_CTRL_PERF_EN
    ,
    output logic [31:0]                    issued_o,
    output logic [31:0]                    stall_o
`endif
);

    localparam int unsigned id_w = lg(num_req_p);
    localparam int unsigned last = pipe_stages_p - 1;

    logic [num_req_p-1:0] grant;
    logic [id_w-1:0]      grant_idx;
    logic                 any;
    logic                 accept;

    bsg_mul_share_tag_s pipe [pipe_stages_p];

    // Holding the multiplier while a result waits keeps tags and products aligned.
    assign mul_en_o = ~pipe[last].v | yumi_i;
    assign accept   = any & mul_en_o;
    assign ready_o  = grant & {num_req_p{mul_en_o}};

    bsg_mul_share_rr_arb #(
        .num_req_p(num_req_p)
    ) arb (
        .clk       (clock_i),
        .rst_n     (reset_n_i),
        .req       (v_i),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    always_comb begin
        mul_x_o      = '0;
        mul_y_o      = '0;
        mul_signed_o = 1'b0;
        for (int unsigned r = 0; r < num_req_p; r++) begin
            if (grant[r]) begin
                mul_x_o      = x_i[r*width_p +: width_p];
                mul_y_o      = y_i[r*width_p +: width_p];
                mul_signed_o = signed_i[r];
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned i = 0; i < pipe_stages_p; i++) begin
                pipe[i] <= '0;
            end
        end else if (mul_en_o) begin
            pipe[0].v  <= accept;
            pipe[0].id <= tag_id_w'(grant_idx);
            for (int unsigned i = 1; i < pipe_stages_p; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign v_o  = pipe[last].v;
    assign id_o = pipe[last].id[id_w-1:0];
    assign z_o  = mul_z_i;

    generate
        if (id_w < tag_id_w) begin : g_id_ext
            assert property (@(posedge clock_i) disable iff (!reset_n_i)
                pipe[last].id[tag_id_w-1:id_w] == '0);
        end
    endgenerate

    assert property (@(posedge clock_i) disable iff (!reset_n_i) yumi_i |-> v_o);

`ifdef BSG_MUL_SHARE_CTRL_PERF_EN
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            issued_o <= '0;
            stall_o  <= '0;
        end else begin
            if (accept && (issued_o != '1)) begin
                issued_o <= issued_o + 1'b1;
            end
            if (v_o && !yumi_i && (stall_o != '1)) begin
                stall_o <= stall_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bsg_mul_share_ctrl.sv
// Self-checking bench for bsg_mul_share_ctrl with a behavioural multiplier and a queue-based reference model.
// Perf counter checks are compiled in when BSG_MUL_SHARE_CTRL_PERF_EN is defined.
module tb_bsg_mul_share_ctrl;

    localparam int W = 32;
    localparam int N = 4;
    localparam int P = 4;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     v_i;
    logic [N*W-1:0]   x_i;
    logic [N*W-1:0]   y_i;
    logic [N-1:0]     signed_i;
    logic [N-1:0]     ready_o;
    logic             mul_en_o;
    logic [W-1:0]     mul_x_o;
    logic [W-1:0]     mul_y_o;
    logic             mul_signed_o;
    logic [2*W-1:0]   mul_z_i;
    logic             v_o;
    logic [1:0]       id_o;
    logic [2*W-1:0]   z_o;
    logic             yumi_i;
`ifdef BSG_MUL_SHARE_CTRL_PERF_EN
    logic [31:0]      issued_o;
    logic [31:0]      stall_o;
`endif

    bsg_mul_share_ctrl #(
        .width_p       (W),
        .num_req_p     (N),
        .pipe_stages_p (P)
    ) dut (
        .clock_i      (clk),
        .reset_n_i    (rst_n),
        .v_i          (v_i),
        .x_i          (x_i),
        .y_i          (y_i),
        .signed_i     (signed_i),
        .ready_o      (ready_o),
        .mul_en_o     (mul_en_o),
        .mul_x_o      (mul_x_o),
        .mul_y_o      (mul_y_o),
        .mul_signed_o (mul_signed_o),
        .mul_z_i      (mul_z_i),
        .v_o          (v_o),
        .id_o         (id_o),
        .z_o          (z_o),
        .yumi_i       (yumi_i)
`ifdef BSG_MUL_SHARE_CTRL_PERF_EN
        ,
        .issued_o     (issued_o),
        .stall_o      (stall_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Stand-in for the shared multiplier: fixed latency, global enable.
    logic [63:0] mpipe [P];
    always @(posedge clk) begin
        if (mul_en_o) begin
            mpipe[0] <= prod(mul_x_o, mul_y_o, mul_signed_o);
            for (int i = 1; i < P; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_z_i = mpipe[P-1];

    // Consumer: 0 = never, 1 = always when v_o, 2 = random when v_o.
    int ymode = 1;
    always @(posedge clk or negedge rst_n) begin
        #1;
        case (ymode)
            0:       yumi_i = 1'b0;
            1:       yumi_i = v_o;
            default: yumi_i = v_o & 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model: in-flight ops in issue order, each aging one step per enabled cycle.
    typedef struct {
        int          id;
        logic [63:0] z;
        int          age;
    } op_t;

    op_t  q[$];
    int   ret_ids[$];
    int   m_ptr, m_issued, m_stall;
    int   g;
    logic exp_v, exp_en;
    logic [N-1:0] exp_ready;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_ptr    = 0;
            m_issued = 0;
            m_stall  = 0;
        end else begin
            exp_v  = (q.size() > 0) && (q[0].age == P);
            exp_en = !exp_v || yumi_i;
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && v_i[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            exp_ready = (g >= 0 && exp_en) ? (N'(1) << g) : '0;
            chk("v_o", v_o, exp_v);
            chk("mul_en_o", mul_en_o, exp_en);
            chk("ready_o", ready_o, exp_ready);
            if (exp_v) begin
                chk("id_o", id_o, q[0].id);
                chk("z_o", z_o, q[0].z);
            end
            if (g >= 0) begin
                chk("mul_x_o", mul_x_o, x_i[g*W +: W]);
                chk("mul_y_o", mul_y_o, y_i[g*W +: W]);
                chk("mul_signed_o", mul_signed_o, signed_i[g]);
            end else begin
                chk("mul_x_o_idle", mul_x_o, 0);
            end
`ifdef BSG_MUL_SHARE_CTRL_PERF_EN
            chk("issued_o", issued_o, m_issued);
            chk("stall_o", stall_o, m_stall);
`endif
            if (exp_en) begin
                if (exp_v) begin
                    ret_ids.push_back(q[0].id);
                    void'(q.pop_front());
                end
                foreach (q[i]) q[i].age++;
                if (g >= 0) begin
                    q.push_back('{g, prod(x_i[g*W +: W], y_i[g*W +: W], signed_i[g]), 1});
                    m_ptr = (g + 1) % N;
                    m_issued++;
                end
            end else begin
                m_stall++;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        v_i   = '0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_op(input int r, input logic [31:0] x, input logic [31:0] y, input logic s);
        x_i[r*W +: W] = x;
        y_i[r*W +: W] = y;
        signed_i[r]   = s;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int cnt;
    logic [1:0]  cap_id;
    logic [63:0] cap_z;
`ifdef BSG_MUL_SHARE_CTRL_PERF_EN
    logic [31:0] s0;
`endif

    initial begin
        v_i = '0; x_i = '0; y_i = '0; signed_i = '0; yumi_i = 1'b0;

        // Reset and idle
        do_reset();
        repeat (10) @(negedge clk);
        chk("idle_v_o", v_o, 0);
        chk("idle_ready_o", ready_o, 0);
        chk("idle_mul_en_o", mul_en_o, 1);
`ifdef BSG_MUL_SHARE_CTRL_PERF_EN
        chk("idle_issued_o", issued_o, 0);
`endif

        // Single requester, unsigned then signed
        @(posedge clk); #1 v_i = 4'b0010; set_op(1, 32'd7, 32'd6, 1'b0);
        @(posedge clk); #1 v_i = '0;
        repeat (2) @(posedge clk); #2 chk("lat_early_v_o", v_o, 0);
        @(posedge clk); #2
        chk("single_v_o", v_o, 1);
        chk("single_id_o", id_o, 1);
        chk("single_z_o", z_o, 64'd42);
        @(posedge clk); #1 v_i = 4'b0010; set_op(1, 32'hFFFF_FFFD, 32'd5, 1'b1);
        @(posedge clk); #1 v_i = '0;
        repeat (3) @(posedge clk); #2
        chk("signed_v_o", v_o, 1);
        chk("signed_z_o", z_o, 64'hFFFF_FFFF_FFFF_FFF1);
        repeat (3) @(posedge clk);

        // Round robin with all requesters active
        do_reset();
        @(posedge clk); #1
        for (int r = 0; r < N; r++) set_op(r, 32'(r + 1), 32'(10 * (r + 1)), 1'b0);
        v_i = 4'hF;
        ret_ids.delete();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 5) chk($sformatf("rr_grant%0d", k), ready_o, 4'b0001 << (k % 4));
        end
        chk("rr_ret_count", (ret_ids.size() >= 5), 1);
        for (int k = 0; k < 5; k++) chk($sformatf("rr_ret_id%0d", k), ret_ids[k], k % 4);

        // Backpressure: 5 stall cycles with the pipe full
        ymode = 0;
        @(posedge clk); #2
        cap_id = id_o;
        cap_z  = z_o;
`ifdef BSG_MUL_SHARE_CTRL_PERF_EN
        s0 = stall_o;
`endif
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_v_o", v_o, 1);
            chk("bp_ready_o", ready_o, 0);
            chk("bp_mul_en_o", mul_en_o, 0);
            chk("bp_id_o", id_o, cap_id);
            chk("bp_z_o", z_o, cap_z);
        end
        ymode = 1;
        @(negedge clk);
`ifdef BSG_MUL_SHARE_CTRL_PERF_EN
        chk("bp_stall_delta", stall_o - s0, 5);
`endif
        @(posedge clk); #1 v_i = '0;
        repeat (12) @(negedge clk);
        chk("bp_drain_empty", q.size(), 0);

        // Reset with three ops in flight
        do_reset();
        @(posedge clk); #1 v_i = 4'b0100; set_op(2, 32'd3, 32'd3, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1 v_i = '0;
        @(posedge clk); #2
        chk("mid_v_o_before", v_o, 1);
        chk("mid_id_before", id_o, 2);
        rst_n = 1'b0;
        #1 chk("mid_v_o_reset", v_o, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            cnt += int'(v_o);
        end
        chk("mid_no_emerge", cnt, 0);
        @(posedge clk); #1 v_i = 4'b0101; set_op(0, 32'd1, 32'd1, 1'b0);
        @(negedge clk);
        chk("mid_ptr_r0", ready_o, 4'b0001);
        @(posedge clk); #1 v_i = '0;
        repeat (8) @(posedge clk);

        // Random soak
        ymode = 2;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1
            v_i = N'($urandom);
            for (int r = 0; r < N; r++) set_op(r, pick(), pick(), 1'($urandom_range(0, 1)));
        end
        @(posedge clk); #1 v_i = '0;
        ymode = 1;
        repeat (20) @(negedge clk);
        chk("soak_drain_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
